// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI input conditioning path.
// Build option INPUT_CONDITIONER_SYNC3_EN selects a 3-flop synchronizer instead of 2.
package spi_pkg;

    localparam int IC_WAIT_TIME_DEF     = 3;
    localparam int IC_COUNTER_WIDTH_DEF = 3;

`ifdef INPUT_CONDITIONER_SYNC3_EN
    localparam int IC_SYNC_STAGES = 3;
`else
    localparam int IC_SYNC_STAGES = 2;
`endif

    typedef enum logic {
        IC_IDLE     = 1'b0,
        IC_COUNTING = 1'b1
    } ic_state_e;

endpackage

// File: rtl/input_conditioner_if.sv
// Pin-side bundle of the input conditioner: raw pin in, clean level and edge strobes out,
// plus FSM state and debounce counter exposed for observation. No handshake: pure levels.
interface input_conditioner_if #(
    parameter int COUNTER_WIDTH = 3
);
    import spi_pkg::*;

    logic                     noisysignal;
    logic                     conditioned;
    logic                     positiveedge;
    logic                     negativeedge;
    ic_state_e                dbg_state;
    logic [COUNTER_WIDTH-1:0] dbg_counter;

    modport master (
        output noisysignal,
        input  conditioned,
        input  positiveedge,
        input  negativeedge,
        input  dbg_state,
        input  dbg_counter
    );

    modport slave (
        input  noisysignal,
        output conditioned,
        output positiveedge,
        output negativeedge,
        output dbg_state,
        output dbg_counter
    );

endinterface

// File: rtl/input_conditioner_sync_ff.sv
// N-stage shift-chain synchronizer with asynchronous active-low reset to 0.
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stage_q;
    logic [DEPTH-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[DEPTH-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes, debounces and edge-detects one raw asynchronous pin.
// Synchronizer depth follows INPUT_CONDITIONER_SYNC3_EN (via spi_pkg::IC_SYNC_STAGES).
module input_conditioner
    import spi_pkg::*;
#(
    parameter int WAIT_TIME     = IC_WAIT_TIME_DEF,
    parameter int COUNTER_WIDTH = IC_COUNTER_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input_conditioner_if.slave  ic
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(WAIT_TIME - 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);

    logic                     sync;
    ic_state_e                state_q, state_d;
    logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
    logic                     conditioned_q, conditioned_d;
    logic                     positiveedge_q, positiveedge_d;
    logic                     negativeedge_q, negativeedge_d;
    logic                     update;

    sync_ff #(
        .DEPTH (IC_SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ic.noisysignal),
        .q     (sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IC_IDLE;
            counter_q      <= '0;
            conditioned_q  <= 1'b0;
            positiveedge_q <= 1'b0;
            negativeedge_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            conditioned_q  <= conditioned_d;
            positiveedge_q <= positiveedge_d;
            negativeedge_q <= negativeedge_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        counter_d      = counter_q;
        conditioned_d  = conditioned_q;
        positiveedge_d = 1'b0;
        negativeedge_d = 1'b0;
        update         = 1'b0;

        case (state_q)
            IC_IDLE: begin
                counter_d = '0;
                if (sync != conditioned_q) begin
                    // A one-cycle wait needs no counting phase at all.
                    if (WAIT_TIME == 1) begin
                        update = 1'b1;
                    end else begin
                        counter_d = CNT_ONE;
                        state_d   = IC_COUNTING;
                    end
                end
            end
            IC_COUNTING: begin
                if (sync == conditioned_q) begin
                    counter_d = '0;
                    state_d   = IC_IDLE;
                end else if (counter_q == CNT_LAST) begin
                    update = 1'b1;
                end else begin
                    counter_d = counter_q + CNT_ONE;
                end
            end
            default: begin
                counter_d = '0;
                state_d   = IC_IDLE;
            end
        endcase

        if (update) begin
            conditioned_d  = sync;
            positiveedge_d = sync;
            negativeedge_d = ~sync;
            counter_d      = '0;
            state_d        = IC_IDLE;
        end
    end

    assign ic.conditioned  = conditioned_q;
    assign ic.positiveedge = positiveedge_q;
    assign ic.negativeedge = negativeedge_q;
    assign ic.dbg_state    = state_q;
    assign ic.dbg_counter  = counter_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios with literal expectations plus random
// pin activity checked every cycle against a run-length model of the debounce rule.
module tb_input_conditioner;
  import spi_pkg::*;

  localparam int W  = IC_WAIT_TIME_DEF;
  localparam int CW = IC_COUNTER_WIDTH_DEF;
`ifdef INPUT_CONDITIONER_SYNC3_EN
  localparam int D = 3;
`else
  localparam int D = 2;
`endif
  // Number of edges after the sampling edge k at which the output changes.
  localparam int LAT = (D - 1) + W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  input_conditioner_if #(.COUNTER_WIDTH(CW)) ic ();

  input_conditioner #(
    .WAIT_TIME     (W),
    .COUNTER_WIDTH (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ic    (ic)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // The clean level follows the synchronized pin once it has disagreed for W edges in a row.
  logic [CW+2:0] exp_q[$];
  logic          sync_hist[$];
  logic          m_cond = 1'b0;
  int            m_run  = 0;

  task automatic model_reset();
    m_cond = 1'b0;
    m_run  = 0;
    sync_hist.delete();
    for (int i = 0; i < D; i++) sync_hist.push_back(1'b0);
  endtask

  initial model_reset();

  always @(negedge rst_n) begin
    model_reset();
    exp_q.delete();
  end

  always @(posedge clk) begin
    logic s, p, n;
    if (!rst_n) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      s = sync_hist.pop_front();
      sync_hist.push_back(ic.noisysignal);
      p = 1'b0;
      n = 1'b0;
      if (s != m_cond) m_run++;
      else m_run = 0;
      if (m_run == W) begin
        m_cond = s;
        p = s;
        n = ~s;
        m_run = 0;
      end
      exp_q.push_back({m_cond, p, n, CW'(m_run)});
    end
  end

  always @(negedge clk) begin
    logic [CW+2:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cond",    32'(ic.conditioned),  32'(e[CW+2]));
      check("posedge", 32'(ic.positiveedge), 32'(e[CW+1]));
      check("negedge", 32'(ic.negativeedge), 32'(e[CW]));
      check("counter", 32'(ic.dbg_counter),  32'(e[CW-1:0]));
      check("state",   32'(ic.dbg_state == IC_COUNTING), 32'(e[CW-1:0] != '0));
      check("strobe_excl", 32'(ic.positiveedge & ic.negativeedge), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change just after the falling edge, clear of both sampling edges.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic c, input logic p, input logic n);
    check({name, "_cond"}, 32'(ic.conditioned),  32'(c));
    check({name, "_pos"},  32'(ic.positiveedge), 32'(p));
    check({name, "_neg"},  32'(ic.negativeedge), 32'(n));
  endtask

  task automatic settle(input logic lvl);
    ic.noisysignal = lvl;
    repeat (LAT + 3) step();
  endtask

  task automatic clean_edge(input string name, input logic lvl);
    ic.noisysignal = lvl;
    for (int j = 1; j <= LAT + 2; j++) begin
      step();
      check_outs(name, (j >= LAT + 1) ? lvl : ~lvl, lvl && (j == LAT + 1), !lvl && (j == LAT + 1));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ic.noisysignal = 1'b0;
    rst_n = 1'b0;

    // Reset held with the pin high: outputs stay 0, then rise at the 5th edge after release.
    ic.noisysignal = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      check_outs("rst_hold", 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    for (int j = 1; j <= LAT + 2; j++) begin
      step();
      check_outs("rst_rel", j >= LAT + 1, j == LAT + 1, 1'b0);
    end

    clean_edge("fall1", 1'b0);
    settle(1'b0);
    clean_edge("rise", 1'b1);
    settle(1'b1);
    clean_edge("fall2", 1'b0);
    settle(1'b0);

    // Glitch two cycles long is rejected.
    ic.noisysignal = 1'b1;
    for (int j = 0; j < 2; j++) begin
      step();
      check_outs("glitch", 1'b0, 1'b0, 1'b0);
    end
    ic.noisysignal = 1'b0;
    for (int j = 0; j < 8; j++) begin
      step();
      check_outs("glitch", 1'b0, 1'b0, 1'b0);
    end
    check("glitch_counter", 32'(ic.dbg_counter), 32'd0);

    // Reset one cycle before the update edge aborts the pending rise.
    ic.noisysignal = 1'b1;
    for (int j = 1; j <= LAT; j++) step();
    check_outs("midrst_pre", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_outs("midrst_async", 1'b0, 1'b0, 1'b0);
    step();
    check_outs("midrst_upd", 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    ic.noisysignal = 1'b0;
    for (int j = 0; j < LAT + 3; j++) begin
      step();
      check_outs("midrst_after", 1'b0, 1'b0, 1'b0);
    end

    // Random pin activity, including short glitches and occasional resets.
    for (int r = 0; r < 400; r++) begin
      ic.noisysignal = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 2 * W + 2)) step();
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 2)) step();
        rst_n = 1'b1;
      end
    end
    repeat (LAT + 3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Conditions one raw asynchronous pin (SPI SCLK, CS or MOSI from the GPIO header) into a clean, clock-domain-safe level plus single-cycle edge strobes. It sits directly upstream of `spiMemory`: the top level instantiates one copy per SPI input pin, and `spiMemory` consumes the `conditioned`, `positiveedge` and `negativeedge` outputs instead of raw pins. The block combines a multi-flop synchronizer, a counter-based debounce/glitch filter and an edge detector.

## Interface
- `WAIT_TIME`, default 3: number of consecutive cycles the synchronized input must differ from `conditioned` before `conditioned` follows it; legal range 1 .. 2^`COUNTER_WIDTH`-1.
- `COUNTER_WIDTH`, default 3: width of the debounce counter.

- `clk`  in  1  system clock; every flop is rising-edge triggered.
- `rst_n`  in  1  asynchronous, active-low reset. Assertion is asynchronous; release is sampled on `clk`.
- `noisysignal`  in  1  raw asynchronous pin.
- `conditioned`  out  1  debounced, synchronized level; registered.
- `positiveedge`  out  1  one-cycle strobe when `conditioned` goes 0->1; registered.
- `negativeedge`  out  1  one-cycle strobe when `conditioned` goes 1->0; registered.

## Operation
- Reset (`rst_n`=0) clears every flop to 0 asynchronously: sync stages, `counter`, state (IDLE), `conditioned`, `positiveedge` and `negativeedge`.
- Synchronizer: `noisysignal` passes through a 2-flop shift chain to produce `sync`. No other logic reads `noisysignal`.
- The FSM has two states: IDLE and COUNTING.
  - IDLE: if `sync`==`conditioned`, stay in IDLE with `counter`=0. If `sync`!=`conditioned` and `WAIT_TIME`==1, update at once (see below). Otherwise set `counter`<=1 and go to COUNTING.
  - COUNTING: if `sync`==`conditioned`, the input was a glitch: set `counter`<=0 and return to IDLE with no output change. If `counter`==`WAIT_TIME`-1, update: `conditioned`<=`sync`, `counter`<=0, go to IDLE. Otherwise `counter`<=`counter`+1.
- On an update, the matching strobe is 1 in the same cycle that `conditioned` changes. `positiveedge` is set if the new value is 1; `negativeedge` is set if it is 0. Both strobes are 0 in every other cycle.
- `positiveedge` and `negativeedge` are never 1 together. The strobes are separated by at least `WAIT_TIME` cycles.
- `counter` never exceeds `WAIT_TIME`-1, so it cannot wrap.
- Reset asserted mid-count aborts the count. The block restarts from IDLE with `conditioned`=0 and emits no strobe.

## Timing
- Let edge k be the first rising edge that samples a new, then-stable `noisysignal`. `sync` shows the new value after edge k+1. `conditioned` and the strobe change at edge k+1+`WAIT_TIME` (for the default, edge k+4).
- A pulse on `sync` lasting fewer than `WAIT_TIME` cycles is rejected entirely.
- Throughput: at most one transition per `WAIT_TIME` cycles. `clk` must be at least 2×`WAIT_TIME`+2 times faster than the fastest SCLK half-period the SPI master generates.

## Configuration
- `INPUT_CONDITIONER_SYNC3_EN`:
  - Defined: the synchronizer has 3 flops. All input-to-output latencies grow by one cycle (update at edge k+2+`WAIT_TIME`).
  - Undefined: 2 flops, as specified above.
  - Debounce and strobe behaviour are otherwise identical.

## Structure
- Shared package `spi_pkg`: the FSM state enum (`IC_IDLE`, `IC_COUNTING`) and the default `WAIT_TIME`/`COUNTER_WIDTH` constants, so the top level and `spiMemory` benches use the same values.
- One sub-module, `sync_ff`: an N-stage synchronizer with a depth parameter (2 or 3, chosen by the macro) and async active-low reset to 0.
- FSM, counter and edge registers live in `input_conditioner` itself.

## Test plan
All scenarios use `WAIT_TIME`=3 and the macro undefined unless noted.
- Reset: hold `rst_n`=0 with `noisysignal`=1 for 5 cycles, then release. All outputs read 0 during reset, and `conditioned` reads 1 only at the 5th edge after release.
- Clean rise: step `noisysignal` 0->1 at edge k. `conditioned` is 1 and `positiveedge` is 1 for exactly one cycle at edge k+4, and `negativeedge` stays 0 throughout.
- Glitch rejection: drive `noisysignal`=1 for 2 cycles, then 0. `conditioned`, `positiveedge` and `negativeedge` stay 0 throughout, and `counter` returns to 0.
- Clean fall after a rise: `negativeedge` pulses once, 4 edges after the falling sample, and `conditioned` reads 0.
- Reset mid-count: assert `rst_n`=0 one cycle before the update edge. No strobe occurs and `conditioned` remains 0.
- Macro defined: repeat the clean-rise scenario. The update moves to edge k+5.
